serial_adder: RTL and testbench

Bit-serial N-bit adder built around a single 1-bit full-adder cell.
- Captures two parallel operands on a start handshake.
- Shifts the operands LSB-first through the cell, one bit per clock, holding the carry in a flip-flop between bits.
- Presents the registered N-bit sum and carry-out with a one-cycle done pulse.
- Sits directly around the team's full-adder cell: feeds it one operand bit pair per cycle and consumes its sum/carry outputs. Used wherever area matters more than latency.

---
 rtl/serial_arith_pkg.sv | 20 ++
 rtl/fa_bit_cell.sv | 13 +
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  // Legal operand widths for serial_adder.
  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

  // Controller states. The encoding is fixed so that ready/busy/done decode cleanly.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } serial_state_e;

  // True when w is a supported operand width.
  function automatic bit width_legal(input int unsigned w);
    return (w >= WidthMin) && (w <= WidthMax);
  endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// 1-bit full adder cell, purely combinational.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, operands shifted LSB-first,
// carry held in a flop between bits. Result is registered and flagged by a done pulse.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // WIDTH >= 2, so the counter is at least one bit and reaches WIDTH-1 without wrapping.
  localparam int unsigned CntW = $clog2(WIDTH);

  serial_state_e state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic cell_s;
  logic cell_c;
  logic last_bit;

  fa_bit_cell u_cell (
    .a  (a_sr_q[0]),
    .b  (b_sr_q[0]),
    .cin(carry_q),
    .s  (cell_s),
    .c  (cell_c)
  );

  assign last_bit = (cnt_q == CntW'(WIDTH - 1));

  // Next-state logic: capture on start, shift one bit per cycle, publish on the last bit.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        // Sum bits enter at the MSB so the first bit ends at bit 0 after WIDTH shifts.
        psum_d  = {cell_s, psum_q[WIDTH-1:1]};
        carry_d = cell_c;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
          sum_d   = {cell_s, psum_q[WIDTH-1:1]};
          cout_d  = cell_c;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status flags decode straight from the state register.
  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_serial_adder;

  logic clk;
  logic rst;

  logic        start8, cin8, ready8, busy8, done8, cout8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, cin16, ready16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  int total;
  int bad;
  int cyc;

  logic [63:0] q8[$];
  logic [63:0] q16[$];
  logic [63:0] held8;
  logic [63:0] held16;
  bit          done8_prev;
  bit          done16_prev;
  bit          period_chk;
  int          last_done8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .ready(ready8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .start(start16),
    .a    (a16),
    .b    (b16),
    .cin  (cin16),
    .ready(ready16),
    .busy (busy16),
    .done (done16),
    .sum  (sum16),
    .cout (cout16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Wait for ready, present one operand set for a single edge and record the expected result.
  task automatic issue(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci);
    bit          ok;
    logic [63:0] e;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if ((w == 8) ? ready8 : ready16) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_wait", 64'(ok), 64'd1);
    if (!ok) return;
    if (w == 8) begin
      a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci; start8 = 1'b1;
      e  = 64'(av[7:0]) + 64'(bv[7:0]) + 64'(ci);
      q8.push_back(e & 64'h1ff);
    end else begin
      a16 = av[15:0]; b16 = bv[15:0]; cin16 = ci; start16 = 1'b1;
      e   = 64'(av[15:0]) + 64'(bv[15:0]) + 64'(ci);
      q16.push_back(e & 64'h1ffff);
    end
    @(posedge clk);
    #1;
    // Scramble the live operands so only the captured copies can produce the right answer.
    if (w == 8) begin
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    end else begin
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q8.size() == 0 && q16.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  // Output monitor: scoreboard pop on done, hold checks otherwise, flag exclusivity.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      check("flags8_onehot", 64'($onehot({ready8, busy8, done8})), 64'd1);
      check("flags16_onehot", 64'($onehot({ready16, busy16, done16})), 64'd1);

      if (done8) begin
        check("done8_pulse", 64'(done8_prev), 64'd0);
        check("sb8_nonempty", 64'(q8.size() > 0), 64'd1);
        if (q8.size() > 0) begin
          e = q8.pop_front();
          check("res8", {55'd0, cout8, sum8}, e);
          held8 = e;
        end
        if (period_chk && last_done8 >= 0) check("period8", 64'(cyc - last_done8), 64'd10);
        last_done8 = cyc;
      end else begin
        check("hold8", {55'd0, cout8, sum8}, held8);
      end

      if (done16) begin
        check("done16_pulse", 64'(done16_prev), 64'd0);
        check("sb16_nonempty", 64'(q16.size() > 0), 64'd1);
        if (q16.size() > 0) begin
          e = q16.pop_front();
          check("res16", {47'd0, cout16, sum16}, e);
          held16 = e;
        end
      end else begin
        check("hold16", {47'd0, cout16, sum16}, held16);
      end

      done8_prev  = done8;
      done16_prev = done16;
    end
  end

  initial begin
    int lat;
    int busy_cnt;
    total = 0; bad = 0; cyc = 0;
    held8 = '0; held16 = '0;
    done8_prev = 1'b0; done16_prev = 1'b0;
    period_chk = 1'b0; last_done8 = -1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    rst = 1'b1;

    // Reset state
    #2;
    check("rst_ready8", 64'(ready8), 64'd1);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_sum8", {55'd0, cout8, sum8}, 64'd0);
    check("rst_ready16", 64'(ready16), 64'd1);
    check("rst_sum16", {47'd0, cout16, sum16}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: latency and busy duration
    issue(8, 32'h0F, 32'h01, 1'b0);
    lat = -1;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) begin
        lat = k;
        break;
      end
    end
    check("latency8", 64'(lat), 64'd8);
    check("busy_cycles8", 64'(busy_cnt), 64'd8);
    drain();

    // 2: carry ripple through all bits
    issue(8, 32'hFF, 32'h01, 1'b0);
    issue(8, 32'hFF, 32'hFF, 1'b1);
    drain();

    // 3: start held high, operands disturbed while busy
    period_chk = 1'b1;
    last_done8 = -1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (i == 44) begin
        start8 = 1'b0;
      end else if (ready8) begin
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        q8.push_back(64'h046);
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    drain();
    period_chk = 1'b0;
    check("held_after_t3", {55'd0, cout8, sum8}, 64'h046);

    // 4: previous result must hold during the next SHIFT phase (monitor hold8)
    issue(8, 32'h80, 32'h80, 1'b0);
    drain();

    // 5: asynchronous reset three cycles into SHIFT
    issue(8, 32'h33, 32'h44, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_ready8", 64'(ready8), 64'd1);
    check("arst_busy8", 64'(busy8), 64'd0);
    check("arst_done8", 64'(done8), 64'd0);
    check("arst_sum8", {55'd0, cout8, sum8}, 64'd0);
    q8.delete();
    held8 = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(8, 32'h05, 32'h03, 1'b0);
    drain();

    // 6: random sweep at both widths
    for (int i = 0; i < 1000; i++) issue(8, $urandom, $urandom, 1'($urandom));
    drain();
    for (int i = 0; i < 1000; i++) issue(16, $urandom, $urandom, 1'($urandom));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
